// File: rtl/mips_multicycle_datapath.sv
// mips_multicycle_datapath: multi-cycle MIPS subset core on a shared, stallable word memory
module mips_multicycle_datapath #(
    parameter int DW = 32,
    parameter int AW = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [AW-1:0] pc,
    output logic          retire,
    output logic          error
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERR} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [DW-1:0] rf_q [32];
    logic [DW-1:0] rf_d [32];
    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, wa;
    logic [DW-1:0] imm, opb, alu_res;
    logic is_r, is_j, is_jal, is_jr, is_beq, is_lw, is_sw, is_ctl, legal;

    assign op = ir_q[31:26];
    assign rs = ir_q[25:21];
    assign rt = ir_q[20:16];
    assign rd = ir_q[15:11];
    assign funct = ir_q[5:0];
    assign imm = {{(DW-16){ir_q[15]}}, ir_q[15:0]};
    assign is_r = op == 6'h00;
    assign is_j = op == 6'h02;
    assign is_jal = op == 6'h03;
    assign is_jr = is_r && funct == 6'h08;
    assign is_beq = op == 6'h04;
    assign is_lw = op == 6'h23;
    assign is_sw = op == 6'h2B;
    assign is_ctl = is_j || is_jal || is_jr;
    assign legal = is_r ? funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08}
                        : op inside {6'h02, 6'h03, 6'h04, 6'h08, 6'h23, 6'h2B};
    assign wa = is_r ? rd : rt;
    assign opb = is_r ? b_q : imm;
    // non-R ops (addi, lw/sw address) always add
    assign alu_res = (!is_r || funct == 6'h20) ? a_q + opb :
                     funct == 6'h22 ? a_q - opb :
                     funct == 6'h24 ? a_q & opb :
                     funct == 6'h25 ? a_q | opb :
                     {{(DW-1){1'b0}}, $signed(a_q) < $signed(opb)};

    assign mem_req = state_q == FETCH || state_q == MEM;
    assign mem_we = state_q == MEM && is_sw;
    assign mem_addr = state_q == MEM ? alu_q[AW-1:0] : pc_q;
    assign mem_wdata = b_q;
    assign pc = pc_q;
    assign error = state_q == ERR;
    assign retire = (state_q == DECODE && is_ctl) || (state_q == EXEC && is_beq) ||
                    (state_q == MEM && is_sw && mem_ready) || state_q == WB;

    // next-state and datapath updates; rf slot 0 is never written so it reads as zero
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        ir_d = ir_q;
        a_d = a_q;
        b_d = b_q;
        alu_d = alu_q;
        mdr_d = mdr_q;
        rf_d = rf_q;
        case (state_q)
            FETCH: if (mem_ready) begin
                ir_d = mem_rdata[31:0];
                pc_d = pc_q + AW'(1);
                state_d = DECODE;
            end
            DECODE: begin
                a_d = rf_q[rs];
                b_d = rf_q[rt];
                state_d = !legal ? ERR : is_ctl ? FETCH : EXEC;
                if (is_j || is_jal) pc_d = ir_q[AW-1:0];
                if (is_jr) pc_d = rf_q[rs][AW-1:0];
                if (is_jal) rf_d[31] = DW'(pc_q);
            end
            EXEC: begin
                alu_d = alu_res;
                state_d = is_beq ? FETCH : (is_lw || is_sw) ? MEM : WB;
                if (is_beq && a_q == b_q) pc_d = pc_q + imm[AW-1:0];
            end
            MEM: if (mem_ready) begin
                mdr_d = mem_rdata;
                state_d = is_lw ? WB : FETCH;
            end
            WB: begin
                state_d = FETCH;
                if (wa != 5'd0) rf_d[wa] = is_lw ? mdr_q : alu_q;
            end
            default: ;
        endcase
    end

    // state and datapath registers; reset overrides any in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q <= RESET_PC;
            ir_q <= '0;
            a_q <= '0;
            b_q <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            ir_q <= ir_d;
            a_q <= a_d;
            b_q <= b_d;
            alu_q <= alu_d;
            mdr_q <= mdr_d;
            rf_q <= rf_d;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// tb_mips_multicycle_datapath: directed and random programs checked against an ISA-level interpreter
module tb_mips_multicycle_datapath;
    logic clk, reset, mem_req, mem_we, mem_ready, retire, error;
    logic [7:0] mem_addr, pc, rpc;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] prog [256];
    logic [31:0] mem [256];
    logic [31:0] rmem [256];
    logic [31:0] rreg [32];
    int passed, total;

    mips_multicycle_datapath dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .retire(retire), .error(error)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 0;
    // free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, o, e);
    endtask

    function automatic logic [31:0] ii(input logic [5:0] o, input logic [4:0] t, input logic [4:0] s, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    function automatic logic [31:0] rr(input logic [5:0] fn, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] jj(input logic [5:0] o, input int tg);
        return {o, 26'(tg)};
    endfunction

    function automatic void wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) rreg[r] = v;
    endfunction

    // executes one instruction of the reference machine; lat=0 means illegal
    task automatic ref_exec(output int lat);
        logic [31:0] ins, s, t, im, ea;
        logic [7:0] npc;
        ins = rmem[rpc];
        s = rreg[ins[25:21]];
        t = rreg[ins[20:16]];
        im = {{16{ins[15]}}, ins[15:0]};
        ea = s + im;
        npc = rpc + 8'd1;
        lat = 4;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: wr(ins[15:11], s + t);
                6'h22: wr(ins[15:11], s - t);
                6'h24: wr(ins[15:11], s & t);
                6'h25: wr(ins[15:11], s | t);
                6'h2A: wr(ins[15:11], ($signed(s) < $signed(t)) ? 32'd1 : 32'd0);
                6'h08: begin npc = s[7:0]; lat = 2; end
                default: lat = 0;
            endcase
            6'h02: begin npc = ins[7:0]; lat = 2; end
            6'h03: begin wr(5'd31, {24'd0, npc}); npc = ins[7:0]; lat = 2; end
            6'h04: begin if (s == t) npc = npc + im[7:0]; lat = 3; end
            6'h08: wr(ins[20:16], ea);
            6'h23: begin wr(ins[20:16], rmem[ea[7:0]]); lat = 5; end
            6'h2B: rmem[ea[7:0]] = t;
            default: lat = 0;
        endcase
        if (lat != 0) rpc = npc;
    endtask

    task automatic gen_rand();
        logic [5:0] fn [5];
        logic [4:0] x, y, z;
        int tgt;
        fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int a = 0; a < 256; a++) prog[a] = (a >= 128 && a < 160) ? $urandom : 32'h0;
        for (int a = 0; a < 40; a++) begin
            x = 5'($urandom);
            y = 5'($urandom);
            z = 5'($urandom);
            tgt = a + 1 + $urandom_range(3, 0);
            if (tgt > 40) tgt = 40;
            case ($urandom_range(9, 0))
                0, 1: prog[a] = ii(6'h08, x, y, 16'($urandom));
                2, 3, 4: prog[a] = rr(fn[$urandom_range(4, 0)], x, y, z);
                5: prog[a] = ii(6'h2B, x, 5'd0, 16'(128 + $urandom_range(31, 0)));
                6: prog[a] = ii(6'h23, x, 5'd0, 16'(128 + $urandom_range(31, 0)));
                7: prog[a] = ii(6'h04, y, z, 16'(tgt - a - 1));
                8: prog[a] = jj(6'h02, tgt);
                default: prog[a] = jj(6'h03, tgt);
            endcase
        end
        for (int i = 1; i < 32; i++) prog[39 + i] = ii(6'h2B, 5'(i), 5'd0, 16'(64 + i));
        prog[71] = 32'hFC00_0000;
    endtask

    // resets the DUT, runs the loaded program with lo..hi stall cycles per access
    task automatic run(input int n_ret, input int lo, input int hi, input bit exp_err);
        int cyc, last, stalls, lat, done, wl;
        bit pend, pstall;
        logic [7:0] paddr;
        for (int a = 0; a < 256; a++) begin mem[a] = prog[a]; rmem[a] = prog[a]; end
        for (int r = 0; r < 32; r++) rreg[r] = 0;
        rpc = 0;
        reset = 1;
        mem_ready = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_error", error, 0);
        chk("rst_retire", retire, 0);
        cyc = 0; last = 0; stalls = 0; done = 0; pend = 0; pstall = 0; paddr = 0;
        wl = $urandom_range(hi, lo);
        while (done < n_ret && !error && cyc < 4000) begin
            cyc++;
            mem_ready = (wl == 0);
            #1;
            if (pend) begin chk("pc", pc, rpc); pend = 0; end
            if (pstall) begin chk("req_hold", mem_req, 1); chk("addr_hold", mem_addr, paddr); end
            pstall = mem_req && !mem_ready;
            paddr = mem_addr;
            if (pstall) begin
                stalls++;
                wl--;
            end else if (mem_req) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                wl = $urandom_range(hi, lo);
            end
            if (retire) begin
                ref_exec(lat);
                chk("latency", cyc - last, lat + stalls);
                last = cyc; stalls = 0; done++; pend = 1;
            end
            @(negedge clk);
        end
        #1;
        if (pend) chk("pc_last", pc, rpc);
        chk("timeout", cyc < 4000, 1);
        chk("error_state", error, exp_err);
        if (exp_err) begin
            for (int k = 0; k < 4; k++) begin
                mem_ready = 1'($urandom);
                #1;
                chk("err_sticky", error, 1);
                chk("err_req", mem_req, 0);
                chk("err_retire", retire, 0);
                chk("err_pc", pc, 8'(rpc + 8'd1));
                @(negedge clk);
            end
            ref_exec(lat);
            chk("ref_illegal", lat, 0);
        end
        for (int a = 0; a < 256; a++) chk($sformatf("mem[%0d]", a), mem[a], rmem[a]);
    endtask

    // directed programs first, then random ones
    initial begin
        passed = 0;
        total = 0;
        reset = 1;
        mem_ready = 0;
        for (int a = 0; a < 256; a++) prog[a] = 0;
        prog[0] = ii(6'h08, 5'd1, 5'd0, 16'd5);
        prog[1] = ii(6'h08, 5'd2, 5'd0, 16'hFFFD);
        prog[2] = rr(6'h20, 5'd3, 5'd1, 5'd2);
        prog[3] = ii(6'h04, 5'd2, 5'd1, 16'd5);
        prog[4] = ii(6'h04, 5'd1, 5'd1, 16'hFFFF);
        run(7, 0, 0, 0);
        chk("beq_loop_pc", pc, 4);

        for (int a = 0; a < 256; a++) prog[a] = 0;
        prog[0] = ii(6'h08, 5'd1, 5'd0, 16'd5);
        prog[1] = ii(6'h08, 5'd2, 5'd0, 16'hFFFD);
        prog[2] = ii(6'h08, 5'd3, 5'd0, 16'd2);
        prog[3] = ii(6'h2B, 5'd3, 5'd0, 16'd40);
        prog[4] = ii(6'h23, 5'd4, 5'd0, 16'd40);
        prog[5] = ii(6'h2B, 5'd4, 5'd0, 16'd41);
        prog[6] = ii(6'h08, 5'd0, 5'd0, 16'd7);
        prog[7] = rr(6'h20, 5'd5, 5'd0, 5'd0);
        prog[8] = ii(6'h2B, 5'd5, 5'd0, 16'd42);
        prog[9] = rr(6'h2A, 5'd6, 5'd2, 5'd1);
        prog[10] = ii(6'h2B, 5'd6, 5'd0, 16'd43);
        prog[11] = jj(6'h03, 20);
        prog[12] = ii(6'h2B, 5'd31, 5'd0, 16'd44);
        prog[13] = 32'hFC00_0000;
        prog[20] = rr(6'h08, 5'd0, 5'd31, 5'd0);
        prog[42] = 32'hDEAD;
        run(1000, 3, 3, 1);
        chk("sw_mem40", mem[40], 2);
        chk("lw_val", mem[41], 2);
        chk("zero_reg", mem[42], 0);
        chk("slt_signed", mem[43], 1);
        chk("jal_link", mem[44], 12);
        chk("err_pc_frozen", pc, 14);

        repeat (3) begin
            gen_rand();
            run(1000, 0, 3, 1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
